imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It receives a byte stream over a valid/ready link, assembles little-endian 32-bit instruction words, and issues word writes at sequential word addresses. It verifies an XOR checksum and holds the core in reset until the image is loaded and verified. It sits between the debug/UART byte receiver and the write port of the writable instruction memory.

---
 rtl/imem_loader.sv | 144 ++++++++++++++
 tb/tb_imem_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the writable instruction memory.
//
// Consumes a framed byte stream (LEN, 4*LEN little-endian data bytes, XOR
// checksum), writes each assembled word at the next sequential word address
// and keeps the core in reset until the image is loaded and verified.
//
// Ports:
//   clk, rst      system clock (rising edge), asynchronous active-high reset
//   start         one-cycle pulse, re-arms the loader from DONE or ERR
//   rx_data       incoming stream byte
//   rx_valid      rx_data is valid
//   rx_ready      loader accepts a byte this cycle (decoded from state)
//   we, wa, wd    instruction-memory write port, one we pulse per word
//   core_hold     holds the core in reset; low only once the image is verified
//   done, err     image verified / length or checksum error
//   words_loaded  words written since the last arm
module imem_loader #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [WIDTH-1:0]  wa,
    output logic [DWIDTH-1:0] wd,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [WIDTH-2:0]  words_loaded
);

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_SUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int unsigned NWORDS = 2 ** (WIDTH - 2);

    state_t           state;
    logic [WIDTH-2:0] len;       // wide enough to hold NWORDS itself
    logic [WIDTH-3:0] idx;
    logic [1:0]       bcnt;
    logic [23:0]      part;      // bytes 0..2 of the word being assembled
    logic [7:0]       csum;

    logic             accept;
    logic [WIDTH-2:0] idx_next;

    assign rx_ready = (state == ST_LEN) || (state == ST_DATA) || (state == ST_SUM);
    assign accept   = rx_valid && rx_ready;
    // One bit wider than idx so completion of word NWORDS-1 compares cleanly
    // against len = NWORDS.
    assign idx_next = {1'b0, idx} + (WIDTH-1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_LEN;
            len          <= '0;
            idx          <= '0;
            bcnt         <= '0;
            part         <= '0;
            csum         <= '0;
            we           <= 1'b0;
            wa           <= '0;
            wd           <= '0;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                ST_LEN: begin
                    if (accept) begin
                        len  <= (WIDTH-1)'(rx_data);
                        bcnt <= '0;
                        idx  <= '0;
                        csum <= '0;
                        if (32'(rx_data) > NWORDS) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end else if (rx_data == 8'h00) begin
                            state <= ST_SUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        csum <= csum ^ rx_data;
                        bcnt <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            // Last byte goes straight into wd; the write
                            // issues on the following cycle.
                            we           <= 1'b1;
                            wa           <= {idx, 2'b00};
                            wd           <= DWIDTH'({rx_data, part});
                            idx          <= idx_next[WIDTH-3:0];
                            words_loaded <= words_loaded + (WIDTH-1)'(1);
                            if (idx_next == len) begin
                                state <= ST_SUM;
                            end
                        end else begin
                            part[8*bcnt +: 8] <= rx_data;
                        end
                    end
                end
                ST_SUM: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (start) begin
                        state        <= ST_LEN;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= '0;
                        core_hold    <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_LEN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed testbench for imem_loader.
//
// Streams hand-built frames into the loader, logs every write pulse and
// compares writes and status flags against hand-computed values.
`timescale 1ns/1ps
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        core_hold;
    logic        done;
    logic        err;
    logic [6:0]  words_loaded;

    int          n_checks;
    int          n_fail;

    logic [7:0]  fr [0:299];
    logic [7:0]  wa_log [0:127];
    logic [31:0] wd_log [0:127];
    int          nw;

    imem_loader #(.DWIDTH(32), .WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .we           (we),
        .wa           (wa),
        .wd           (wd),
        .core_hold    (core_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (we) begin
            if (nw < 128) begin
                wa_log[nw] = wa;
                wd_log[nw] = wd;
            end
            nw = nw + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int w;
        if (gaps) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        w = 0;
        while (!rx_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w == 50) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit gaps);
        for (int i = 0; i < n; i++) send_byte(fr[i], gaps);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic build_two_word(input logic [7:0] sum);
        fr[0] = 8'h02;
        fr[1] = 8'h93; fr[2] = 8'h00; fr[3] = 8'h30; fr[4] = 8'h00;
        fr[5] = 8'h13; fr[6] = 8'h01; fr[7] = 8'h90; fr[8] = 8'h00;
        fr[9] = sum;
    endtask

    task automatic check_two_word_ok(input string tag);
        @(negedge clk);
        check({tag, "_nw"},   32'(nw), 32'd2);
        check({tag, "_wa0"},  32'(wa_log[0]), 32'h00);
        check({tag, "_wd0"},  wd_log[0], 32'h00300093);
        check({tag, "_wa1"},  32'(wa_log[1]), 32'h04);
        check({tag, "_wd1"},  wd_log[1], 32'h00900113);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_hold"}, 32'(core_hold), 32'd0);
        check({tag, "_err"},  32'(err), 32'd0);
        check({tag, "_wl"},   32'(words_loaded), 32'd2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nw       = 0;
        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        check("rst_we",   32'(we), 32'd0);
        check("rst_wa",   32'(wa), 32'd0);
        check("rst_wd",   wd, 32'd0);
        check("rst_hold", 32'(core_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err), 32'd0);
        check("rst_wl",   32'(words_loaded), 32'd0);
        check("rst_nw",   32'(nw), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_ready", 32'(rx_ready), 32'd1);

        // Two-word image, good checksum
        build_two_word(8'h21);
        nw = 0;
        send_frame(10, 1'b0);
        check_two_word_ok("load2");
        pulse_start();
        check("rearm_done",  32'(done), 32'd0);
        check("rearm_hold",  32'(core_hold), 32'd1);
        check("rearm_ready", 32'(rx_ready), 32'd1);
        check("rearm_wl",    32'(words_loaded), 32'd0);

        // Bad checksum: writes happen, then ERR
        build_two_word(8'h20);
        nw = 0;
        send_frame(10, 1'b0);
        @(negedge clk);
        check("bad_nw",    32'(nw), 32'd2);
        check("bad_wd1",   wd_log[1], 32'h00900113);
        check("bad_err",   32'(err), 32'd1);
        check("bad_done",  32'(done), 32'd0);
        check("bad_hold",  32'(core_hold), 32'd1);
        check("bad_ready", 32'(rx_ready), 32'd0);
        pulse_start();
        check("rearm_err", 32'(err), 32'd0);

        // Empty image
        fr[0] = 8'h00; fr[1] = 8'h00;
        nw = 0;
        send_frame(2, 1'b0);
        @(negedge clk);
        check("empty_nw",   32'(nw), 32'd0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_wl",   32'(words_loaded), 32'd0);
        pulse_start();
        fr[0] = 8'h00; fr[1] = 8'h05;
        send_frame(2, 1'b0);
        check("empty_bad_err", 32'(err), 32'd1);
        pulse_start();

        // LEN one past capacity
        nw = 0;
        send_byte(8'h41, 1'b0);
        check("len41_err",   32'(err), 32'd1);
        check("len41_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        check("len41_nw",    32'(nw), 32'd0);
        pulse_start();

        // Full capacity: byte values 0..255, XOR of all is 0
        fr[0] = 8'h40;
        for (int i = 0; i < 256; i++) fr[i+1] = 8'(i);
        fr[257] = 8'h00;
        nw = 0;
        send_frame(258, 1'b0);
        @(negedge clk);
        check("full_nw",    32'(nw), 32'd64);
        check("full_wd0",   wd_log[0], 32'h03020100);
        check("full_wa63",  32'(wa_log[63]), 32'hFC);
        check("full_wd63",  wd_log[63], 32'hFFFEFDFC);
        check("full_done",  32'(done), 32'd1);
        check("full_wl",    32'(words_loaded), 32'd64);
        pulse_start();

        // Two-word image with random idle gaps
        build_two_word(8'h21);
        nw = 0;
        send_frame(10, 1'b1);
        check_two_word_ok("gaps");
        pulse_start();

        // Reset mid-frame after the first word completes
        nw = 0;
        send_frame(5, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_nw",   32'(nw), 32'd1);
        check("abort_wa0",  32'(wa_log[0]), 32'h00);
        check("abort_we",   32'(we), 32'd0);
        check("abort_wa",   32'(wa), 32'd0);
        check("abort_wd",   wd, 32'd0);
        check("abort_hold", 32'(core_hold), 32'd1);
        check("abort_wl",   32'(words_loaded), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nw = 0;
        send_frame(10, 1'b0);
        check_two_word_ok("reload");
        pulse_start();
        check("final_done",  32'(done), 32'd0);
        check("final_hold",  32'(core_hold), 32'd1);
        check("final_ready", 32'(rx_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
